// File: rtl/dm_ctrl.sv
// dm_ctrl: byte-enabled data RAM behind a valid/ready port with clear-on-reset, range check, fixed read latency and a store trace FIFO
module dm_ctrl #(
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1,
  parameter int          TRACE_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow,
  output logic        init_done
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int TW = $clog2(TRACE_DEPTH);
  typedef enum logic [1:0] {CLEAR, IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] t_pc [TRACE_DEPTH];
  logic [31:0] t_addr [TRACE_DEPTH];
  logic [31:0] t_data [TRACE_DEPTH];
  logic [AW-1:0] clr_idx, widx, mem_waddr;
  logic [31:0] offset, old_word, merged, mem_wdata, pend_data;
  logic [3:0] lat;
  logic [TW-1:0] wp, rp;
  logic [TW:0] cnt;
  logic pend_err, in_range, accept, clr_last, mem_we, push, pop, push_ok;

  // address decode, byte-lane merge, write-port select and trace FIFO handshake
  always_comb begin
    offset = req_addr - BASE_ADDR;
    in_range = (req_addr >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH_WORDS));
    widx = offset[AW+1:2];
    old_word = mem[widx];
    merged = old_word;
    for (int k = 0; k < 4; k++) merged[8*k +: 8] = req_byteen[k] ? req_wdata[8*k +: 8] : old_word[8*k +: 8];
    clr_last = clr_idx == AW'(DEPTH_WORDS - 1);
    req_ready = state == IDLE;
    accept = req_valid && req_ready;
    push = accept && in_range && (req_byteen != 4'b0000);
    mem_we = (state == CLEAR) || push;
    mem_waddr = (state == CLEAR) ? clr_idx : widx;
    mem_wdata = (state == CLEAR) ? 32'h0 : merged;
    trace_valid = cnt != '0;
    pop = trace_valid && trace_ready;
    push_ok = push && ((cnt != (TW+1)'(TRACE_DEPTH)) || pop);
    trace_pc = t_pc[rp];
    trace_addr = t_addr[rp];
    trace_data = t_data[rp];
  end

  // next state: clear sweep, then one request at a time until its latency expires
  always_comb begin
    state_nx = (state == CLEAR && clr_last) ? IDLE :
               accept ? BUSY :
               (state == BUSY && lat == 4'd0) ? IDLE : state;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else state <= state_nx;
  end

  // clear index, latency counter, pending and presented response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_idx <= '0;
      lat <= '0;
      pend_data <= '0;
      pend_err <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      init_done <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
      if (state == CLEAR && clr_last) init_done <= 1'b1;
      if (accept) begin
        lat <= 4'(READ_LATENCY - 1);
        pend_data <= in_range ? old_word : 32'h0;
        pend_err <= !in_range;
      end else if (state == BUSY) begin
        lat <= lat - 4'd1;
        if (lat == 4'd0) begin
          resp_valid <= 1'b1;
          resp_rdata <= pend_data;
          resp_err <= pend_err;
        end
      end
    end
  end

  // trace FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (pop) rp <= rp + TW'(1);
      if (push_ok) wp <= wp + TW'(1);
      cnt <= cnt + (TW+1)'(push_ok) - (TW+1)'(pop);
      if (push && !push_ok) trace_overflow <= 1'b1;
    end
  end

  // storage arrays: RAM write port and trace FIFO entries
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (push_ok) begin
      t_pc[wp] <= req_pc;
      t_addr[wp] <= req_addr & 32'hFFFF_FFFC;
      t_data[wp] <= merged;
    end
  end
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed bench with a transaction-level reference model for dm_ctrl
module tb_dm_ctrl;
  localparam int D = 16;
  localparam int TD = 4;
  localparam int RL = 2;
  localparam logic [31:0] BA = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] vld = '0;
  logic [31:0] addr = '0, wdata = '0, pc = '0;
  logic [3:0] byteen = '0;
  logic tr_rdy = 1'b0;
  logic [2:0] rdy, rv, er, tv, ovf, ind;
  logic [31:0] rd [3];
  logic [31:0] tpc [3];
  logic [31:0] tad [3];
  logic [31:0] tdt [3];
  int cyc = 0, n_cmp = 0, n_bad = 0, r0 = 0, n_drain = 0;
  logic [31:0] dpc [8];
  logic [31:0] dad [8];
  logic [31:0] ddt [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: main config; 1: BASE_ADDR=0x100, latency 8; 2: latency 1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dm_ctrl #(
      .DEPTH_WORDS(D), .BASE_ADDR(g == 1 ? 32'h100 : 32'h0),
      .READ_LATENCY(g == 0 ? RL : (g == 1 ? 8 : 1)), .TRACE_DEPTH(TD)
    ) u (
      .clk(clk), .reset(reset), .req_valid(vld[g]), .req_ready(rdy[g]),
      .req_addr(addr), .req_wdata(wdata), .req_byteen(byteen), .req_pc(pc),
      .resp_valid(rv[g]), .resp_rdata(rd[g]), .resp_err(er[g]),
      .trace_valid(tv[g]), .trace_ready(g == 0 ? tr_rdy : 1'b1),
      .trace_pc(tpc[g]), .trace_addr(tad[g]), .trace_data(tdt[g]),
      .trace_overflow(ovf[g]), .init_done(ind[g])
    );
  end

  // reference model of instance 0: memory image, response timer, trace queue
  typedef struct {logic [31:0] pc; logic [31:0] a; logic [31:0] d;} rec_t;
  rec_t q[$];
  logic [31:0] m_mem [D];
  int m_clr = D, m_busy = 0, m_w = 0;
  bit m_init = 0, m_rv = 0, m_err = 0, m_ovf = 0, m_perr = 0, m_pop = 0;
  logic [31:0] m_rd = '0, m_pend = '0, m_mask = '0, m_new = '0;
  longint m_off = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_clr = D; m_busy = 0; m_init = 0; m_rv = 0; m_rd = '0; m_err = 0; m_ovf = 0;
      q.delete();
      foreach (m_mem[i]) m_mem[i] = '0;
    end else begin
      m_pop = (q.size() != 0) && tr_rdy;
      if (m_pop) void'(q.pop_front());
      m_rv = 0;
      if (m_clr > 0) begin
        m_clr--;
        if (m_clr == 0) m_init = 1;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_rv = 1; m_rd = m_pend; m_err = m_perr; end
      end else if (vld[0]) begin
        m_busy = RL;
        m_off = longint'(addr) - longint'(BA);
        if (m_off >= 0 && m_off / 4 < D) begin
          m_w = int'(m_off / 4);
          m_pend = m_mem[m_w];
          m_perr = 0;
          if (byteen != 4'b0) begin
            m_mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
            m_new = (m_pend & ~m_mask) | (wdata & m_mask);
            m_mem[m_w] = m_new;
            if (q.size() < TD) q.push_back('{pc, addr & 32'hFFFF_FFFC, m_new});
            else m_ovf = 1;
          end
        end else begin
          m_pend = '0;
          m_perr = 1;
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic tmo(input string n);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (cycle %0d)", n, cyc);
  endtask

  // per-cycle compare of instance 0 against the model
  initial forever begin
    @(negedge clk);
    chk("ready", 32'(rdy[0]), 32'(m_init && m_busy == 0));
    chk("resp_valid", 32'(rv[0]), 32'(m_rv));
    chk("resp_rdata", rd[0], m_rd);
    chk("resp_err", 32'(er[0]), 32'(m_err));
    chk("trace_valid", 32'(tv[0]), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("trace_pc", tpc[0], q[0].pc);
      chk("trace_addr", tad[0], q[0].a);
      chk("trace_data", tdt[0], q[0].d);
    end
    chk("trace_overflow", 32'(ovf[0]), 32'(m_ovf));
    chk("init_done", 32'(ind[0]), 32'(m_init));
  end

  task automatic wait_init();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (ind[0]) begin ok = 1; chk("clear_cycles", 32'(cyc - r0), 32'd16); end
    end
    if (!ok) tmo("init_done");
    @(posedge clk); #1;
  endtask

  task automatic xact(input int s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] p, input bit pa, output logic [31:0] r, output logic e);
    bit ok = 0;
    r = '0; e = 1'b0;
    addr = a; wdata = d; byteen = be; pc = p; vld[s] = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); ok = rdy[s]; end
    if (!ok) tmo("accept");
    if (pa) tr_rdy = 1'b1;
    @(posedge clk); #1;
    vld[s] = 1'b0;
    if (pa) tr_rdy = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rv[s]) begin ok = 1; r = rd[s]; e = er[s]; end
    end
    if (!ok) tmo("response");
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit done = 0;
    n_drain = 0;
    tr_rdy = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!tv[0]) done = 1;
      else begin
        if (n_drain < 8) begin dpc[n_drain] = tpc[0]; dad[n_drain] = tad[0]; ddt[n_drain] = tdt[0]; end
        n_drain++;
      end
    end
    if (!done) tmo("drain");
    @(posedge clk); #1;
    tr_rdy = 1'b0;
  endtask

  task automatic b2b(input int s, input int rl);
    int acc[3];
    int rsp[3];
    int na = 0, nr = 0;
    addr = (s == 1) ? 32'h100 : 32'h0; byteen = '0; wdata = '0; vld[s] = 1'b1;
    for (int i = 0; i < 120 && nr < 3; i++) begin
      @(negedge clk);
      if (vld[s] && rdy[s] && na < 3) begin acc[na] = cyc + 1; na++; end
      if (rv[s] && nr < 3) begin rsp[nr] = cyc; nr++; end
      @(posedge clk); #1;
      if (na == 3) vld[s] = 1'b0;
    end
    vld[s] = 1'b0;
    chk("b2b_responses", 32'(nr), 32'd3);
    for (int k = 1; k < na; k++) chk("b2b_accept_gap", 32'(acc[k] - acc[0]), 32'(k * (rl + 1)));
    for (int k = 0; k < nr; k++) chk("b2b_resp_latency", 32'(rsp[k] - acc[k]), 32'(rl));
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    r0 = cyc;
    wait_init();
    xact(0, 32'h3C, 32'h0, 4'h0, 32'h1000, 0, r, e);
    chk("clear_load_rd", r, 32'h0);
    chk("clear_load_err", 32'(e), 32'd0);
    xact(0, 32'h8, 32'h1234_5678, 4'hF, 32'h400, 0, r, e);
    xact(0, 32'hA, 32'hAABB_CCDD, 4'b0100, 32'h404, 0, r, e);
    chk("merge_old_word", r, 32'h1234_5678);
    xact(0, 32'h8, 32'h0, 4'h0, 32'h408, 0, r, e);
    chk("merge_load", r, 32'h12BB_5678);
    drain();
    chk("merge_trace_count", 32'(n_drain), 32'd2);
    chk("merge_t0_pc", dpc[0], 32'h400);
    chk("merge_t0_addr", dad[0], 32'h8);
    chk("merge_t0_data", ddt[0], 32'h1234_5678);
    chk("merge_t1_pc", dpc[1], 32'h404);
    chk("merge_t1_addr", dad[1], 32'h8);
    chk("merge_t1_data", ddt[1], 32'h12BB_5678);
    xact(0, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h420, 0, r, e);
    chk("range_err", 32'(e), 32'd1);
    chk("range_rd", r, 32'h0);
    chk("range_no_trace", 32'(tv[0]), 32'd0);
    xact(0, 32'h0, 32'h0, 4'h0, 32'h424, 0, r, e);
    chk("range_untouched", r, 32'h0);
    xact(1, 32'hFC, 32'h0, 4'h0, 32'h428, 0, r, e);
    chk("base_below_err", 32'(e), 32'd1);
    chk("base_below_rd", r, 32'h0);
    xact(1, 32'h100, 32'h0, 4'h0, 32'h42C, 0, r, e);
    chk("base_in_err", 32'(e), 32'd0);
    b2b(0, 2);
    b2b(1, 8);
    b2b(2, 1);
    for (int i = 0; i < 5; i++) xact(0, 32'(4 * i), 32'(i + 1), 4'hF, 32'(32'h500 + 4 * i), 0, r, e);
    chk("full_overflow", 32'(ovf[0]), 32'd1);
    xact(0, 32'h8, 32'h77, 4'hF, 32'h514, 1, r, e);
    chk("full_overflow_held", 32'(ovf[0]), 32'd1);
    drain();
    chk("full_count", 32'(n_drain), 32'd4);
    chk("full_head_pc", dpc[0], 32'h504);
    chk("full_tail_pc", dpc[3], 32'h514);
    chk("full_tail_data", ddt[3], 32'h77);
    addr = 32'h4; wdata = 32'hDEAD_BEEF; byteen = 4'hF; pc = 32'h600; vld[0] = 1'b1;
    begin
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = rdy[0]; end
      if (!ok) tmo("busy_accept");
    end
    @(posedge clk); #1;
    vld[0] = 1'b0;
    chk("busy_trace_pending", 32'(tv[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_resp_valid", 32'(rv[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'h0);
    chk("rst_err", 32'(er[0]), 32'd0);
    chk("rst_trace_valid", 32'(tv[0]), 32'd0);
    chk("rst_overflow", 32'(ovf[0]), 32'd0);
    chk("rst_init_done", 32'(ind[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    r0 = cyc;
    wait_init();
    xact(0, 32'h4, 32'h0, 4'h0, 32'h604, 0, r, e);
    chk("reclear_load", r, 32'h0);
    chk("reclear_fifo_empty", 32'(tv[0]), 32'd0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
